// File: rtl/sdram_ctrl_pkg.sv
// Shared SDRAM controller definitions: command encodings, FSM states, exit causes.
package sdram_ctrl_pkg;

  // {CS,RAS,CAS,WE}
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;

  // Address bit that selects auto-precharge on WRITE and all-banks on PRE
  localparam int unsigned A10_BIT = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACT,
    ST_RCD,
    ST_WRITE,
    ST_WR_REC,
    ST_PRE,
    ST_RP
  } state_t;

  // Why the open row is being closed; selects the exit taken out of RP
  typedef enum logic [1:0] {
    CAUSE_FINAL,
    CAUSE_YIELD,
    CAUSE_ROWX
  } cause_t;

endpackage

// File: rtl/sdram_addr_gen.sv
// Bank/row/column pointer plus remaining-burst counter for the burst writer.
module sdram_addr_gen #(
  parameter int unsigned ROW_WIDTH  = 12,
  parameter int unsigned COL_WIDTH  = 8,
  parameter int unsigned BANK_WIDTH = 2,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  advance,
  input  logic [BANK_WIDTH-1:0] load_bank,
  input  logic [ROW_WIDTH-1:0]  load_row,
  input  logic [COL_WIDTH-1:0]  load_col,
  input  logic [LEN_WIDTH-1:0]  load_num,
  output logic [BANK_WIDTH-1:0] bank,
  output logic [ROW_WIDTH-1:0]  row,
  output logic [COL_WIDTH-1:0]  col,
  output logic                  col_wrap,
  output logic                  rem_last
);

  // Columns are always burst-aligned
  localparam logic [COL_WIDTH-1:0] COL_MASK = ~(COL_WIDTH'(BURST_LEN - 1));

  logic [COL_WIDTH:0]   col_sum;
  logic [LEN_WIDTH-1:0] remaining;

  // Carry out of the column add means the next burst belongs to the next row
  assign col_sum  = {1'b0, col} + (COL_WIDTH + 1)'(BURST_LEN);
  assign col_wrap = col_sum[COL_WIDTH];
  assign rem_last = (remaining == LEN_WIDTH'(1));

  // Pointer load on start, advance by one burst at each burst's last beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank      <= '0;
      row       <= '0;
      col       <= '0;
      remaining <= '0;
    end else if (load) begin
      bank      <= load_bank;
      row       <= load_row;
      col       <= load_col & COL_MASK;
      remaining <= load_num;
    end else if (advance) begin
      col       <= col_sum[COL_WIDTH-1:0];
      remaining <= remaining - 1'b1;
      if (col_wrap) begin
        row <= row + 1'b1;
        if (&row) begin
          bank <= bank + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sdram_burst_writer.sv
// SDRAM write engine: drains a show-ahead FIFO into bursts of WRITE commands,
// crossing column/row/bank boundaries and yielding to refresh between bursts.
module sdram_burst_writer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ROW_WIDTH  = 12,
  parameter int unsigned COL_WIDTH  = 8,
  parameter int unsigned BANK_WIDTH = 2,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned T_RCD      = 2,
  parameter int unsigned T_WR       = 2,
  parameter int unsigned T_RP       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_start,
  input  logic [BANK_WIDTH-1:0] start_bank,
  input  logic [ROW_WIDTH-1:0]  start_row,
  input  logic [COL_WIDTH-1:0]  start_col,
  input  logic [LEN_WIDTH-1:0]  burst_num,
  input  logic                  wr_en,
  input  logic                  ref_rq,
  output logic                  wr_rq,
  output logic                  wr_busy,
  output logic                  wr_done,
  output logic                  wr_yield,
  output logic [3:0]            wr_cmd,
  output logic [ROW_WIDTH-1:0]  wr_addr,
  output logic [BANK_WIDTH-1:0] wr_bank_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wfifo_rd_en,
  input  logic [DATA_WIDTH-1:0] wfifo_rd_data,
  input  logic [LEN_WIDTH-1:0]  wfifo_count
);

  import sdram_ctrl_pkg::*;

  localparam int unsigned TMR_W  = 8;
  localparam int unsigned BEAT_W = 4;

  state_t                state_q, state_d;
  cause_t                cause_q, cause_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic                  active_q, active_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [BEAT_W-1:0]     cur_beat;
  logic                  last_beat;
  logic                  fifo_ready;

  logic [3:0]            cmd_d;
  logic [ROW_WIDTH-1:0]  addr_d;
  logic [BANK_WIDTH-1:0] bank_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  done_d;
  logic                  yield_d;

  logic                  ag_load;
  logic                  ag_adv;
  logic [BANK_WIDTH-1:0] ptr_bank;
  logic [ROW_WIDTH-1:0]  ptr_row;
  logic [COL_WIDTH-1:0]  ptr_col;
  logic                  col_wrap;
  logic                  rem_last;

  sdram_addr_gen #(
    .ROW_WIDTH  (ROW_WIDTH),
    .COL_WIDTH  (COL_WIDTH),
    .BANK_WIDTH (BANK_WIDTH),
    .BURST_LEN  (BURST_LEN),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (ag_load),
    .advance   (ag_adv),
    .load_bank (start_bank),
    .load_row  (start_row),
    .load_col  (start_col),
    .load_num  (burst_num),
    .bank      (ptr_bank),
    .row       (ptr_row),
    .col       (ptr_col),
    .col_wrap  (col_wrap),
    .rem_last  (rem_last)
  );

  assign wr_rq      = (state_q == ST_REQ);
  assign wr_busy    = (state_q != ST_IDLE);
  // Beat 0 of a burst is the cycle in which the FIFO check passes
  assign cur_beat   = active_q ? beat_q : '0;
  assign last_beat  = (cur_beat == BEAT_W'(BURST_LEN - 1));
  assign fifo_ready = (wfifo_count >= LEN_WIDTH'(BURST_LEN));

  // State, timers and registered bus outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cause_q      <= CAUSE_FINAL;
      tmr_q        <= '0;
      active_q     <= 1'b0;
      beat_q       <= '0;
      wr_cmd       <= CMD_NOP;
      wr_addr      <= '0;
      wr_bank_addr <= '0;
      wr_data      <= '0;
      wr_done      <= 1'b0;
      wr_yield     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cause_q      <= cause_d;
      tmr_q        <= tmr_d;
      active_q     <= active_d;
      beat_q       <= beat_d;
      wr_cmd       <= cmd_d;
      wr_addr      <= addr_d;
      wr_bank_addr <= bank_d;
      wr_data      <= data_d;
      wr_done      <= done_d;
      wr_yield     <= yield_d;
    end
  end

  // Next-state, command and FIFO pop decisions
  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    tmr_d       = tmr_q;
    active_d    = active_q;
    beat_d      = beat_q;
    cmd_d       = CMD_NOP;
    addr_d      = wr_addr;
    bank_d      = wr_bank_addr;
    data_d      = wr_data;
    done_d      = 1'b0;
    yield_d     = 1'b0;
    wfifo_rd_en = 1'b0;
    ag_load     = 1'b0;
    ag_adv      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (wr_start) begin
          ag_load = 1'b1;
          if (burst_num == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        if (wr_en) begin
          state_d = ST_ACT;
        end
      end

      ST_ACT: begin
        cmd_d  = CMD_ACT;
        addr_d = ptr_row;
        bank_d = ptr_bank;
        tmr_d  = TMR_W'(T_RCD - 1);
        state_d = (T_RCD > 1) ? ST_RCD : ST_WRITE;
      end

      ST_RCD: begin
        if (tmr_q <= TMR_W'(1)) begin
          state_d = ST_WRITE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end

      ST_WRITE: begin
        if (active_q || fifo_ready) begin
          wfifo_rd_en = 1'b1;
          data_d      = wfifo_rd_data;
          if (!active_q) begin
            cmd_d  = CMD_WRITE;
            addr_d = '0;
            addr_d[COL_WIDTH-1:0] = ptr_col;
            bank_d = ptr_bank;
          end
          if (last_beat) begin
            // Pointer advance and the close decision share this cycle, so the
            // decision uses the pre-advance remaining/wrap flags
            ag_adv   = 1'b1;
            active_d = 1'b0;
            beat_d   = '0;
            if (rem_last) begin
              cause_d = CAUSE_FINAL;
              tmr_d   = TMR_W'(T_WR);
              state_d = ST_WR_REC;
            end else if (ref_rq) begin
              cause_d = CAUSE_YIELD;
              tmr_d   = TMR_W'(T_WR);
              state_d = ST_WR_REC;
            end else if (col_wrap) begin
              cause_d = CAUSE_ROWX;
              tmr_d   = TMR_W'(T_WR);
              state_d = ST_WR_REC;
            end
          end else begin
            active_d = 1'b1;
            beat_d   = cur_beat + 1'b1;
          end
        end else if (ref_rq) begin
          cause_d = CAUSE_YIELD;
          tmr_d   = TMR_W'(T_WR);
          state_d = ST_WR_REC;
        end
      end

      ST_WR_REC: begin
        if (tmr_q <= TMR_W'(1)) begin
          state_d = ST_PRE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end

      ST_PRE: begin
        cmd_d  = CMD_PRE;
        addr_d = '0;
        addr_d[A10_BIT] = 1'b1;
        tmr_d  = TMR_W'(T_RP);
        state_d = ST_RP;
      end

      ST_RP: begin
        if (tmr_q <= TMR_W'(1)) begin
          case (cause_q)
            CAUSE_FINAL: begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
            CAUSE_YIELD: begin
              yield_d = 1'b1;
              state_d = ST_REQ;
            end
            default: begin
              state_d = ST_ACT;
            end
          endcase
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
